// File: rtl/assoc_search_seq_ctrl.sv
// Sequential associative-search controller: streams the query and every class
// hypervector one 512-bit chunk per cycle, popcounts query & class with one
// shared adder tree, accumulates per-class overlap and keeps the argmax.

// Population count of a 512-bit word as a balanced pairwise adder tree.
module tree_add_512bit (
   input  logic [511:0] bits_i,
   output logic [9:0]   sum_o
);
   logic [9:0] lvl [0:511];

   // Halve the number of partial sums each level until one remains in lvl[0].
   always_comb begin
      for (int i = 0; i < 512; i++) lvl[i] = 10'(bits_i[i]);
      for (int w = 256; w >= 1; w = w / 2) begin
         for (int i = 0; i < w; i++) lvl[i] = lvl[2*i] + lvl[2*i+1];
      end
      sum_o = lvl[0];
   end
endmodule

module assoc_search_seq_ctrl #(
   parameter int NUM_CLASSES = 16,
   parameter int CHUNKS      = 4,
   parameter int CLASS_W     = 4,
   parameter int SCORE_W     = 12,
   parameter int CADDR_W     = 6,
   parameter int QADDR_W     = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               q_en,
   output logic [QADDR_W-1:0] q_addr,
   input  logic [511:0]       q_rdata,
   output logic               c_en,
   output logic [CADDR_W-1:0] c_addr,
   input  logic [511:0]       c_rdata,
   output logic               busy,
   output logic               done,
   output logic [CLASS_W-1:0] best_class,
   output logic [SCORE_W-1:0] best_score
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [QADDR_W-1:0]   k_q, k_d;
   logic [CLASS_W-1:0]   cls_q, cls_d;
   logic                 start_acc;
   logic                 issue, last_k, last_cls;

   // Tags of the chunk whose memory read is in flight.
   logic                 vld_p0, first_p0, last_p0;
   logic [CLASS_W-1:0]   cls_p0;
   // Registered popcount of one chunk plus its tags.
   logic                 vld_p1, first_p1, last_p1;
   logic [CLASS_W-1:0]   cls_p1;
   logic [9:0]           pc_p1;
   logic [9:0]           pc_w;
   logic [511:0]         and_w;

   logic [SCORE_W-1:0]   acc_q, acc_next;
   logic [SCORE_W-1:0]   best_score_q;
   logic [CLASS_W-1:0]   best_class_q;
   logic                 bv_q;

   assign issue    = (state_q == S_ISSUE);
   assign last_k   = (k_q == QADDR_W'(CHUNKS - 1));
   assign last_cls = (cls_q == CLASS_W'(NUM_CLASSES - 1));

   // State and loop counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         cls_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         cls_q   <= cls_d;
      end
   end

   // Next state: chunk is the inner loop, class the outer loop; DRAIN lasts
   // until the final read has left the memory stage.
   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      cls_d     = cls_q;
      start_acc = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_ISSUE;
               k_d       = '0;
               cls_d     = '0;
               start_acc = 1'b1;
            end
         end
         S_ISSUE: begin
            if (last_k) begin
               k_d   = '0;
               cls_d = cls_q + 1'b1;
               if (last_cls) state_d = S_DRAIN;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (!vld_p0) state_d = S_DONE;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign q_en   = issue;
   assign c_en   = issue;
   assign q_addr = issue ? k_q : '0;
   assign c_addr = issue ? (CADDR_W'(cls_q) * CADDR_W'(CHUNKS) + CADDR_W'(k_q)) : '0;
   assign busy   = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign done   = (state_q == S_DONE);

   assign and_w = q_rdata & c_rdata;

   tree_add_512bit u_tree (
      .bits_i (and_w),
      .sum_o  (pc_w)
   );

   // ---- stage p0: read issued, tags wait for memory data ----
   always_ff @(posedge clk) begin
      if (rst) vld_p0 <= 1'b0;
      else     vld_p0 <= issue;
      first_p0 <= (k_q == '0);
      last_p0  <= last_k;
      cls_p0   <= cls_q;
   end

   // ---- stage p1: popcount of the returned chunk pair ----
   always_ff @(posedge clk) begin
      if (rst) vld_p1 <= 1'b0;
      else     vld_p1 <= vld_p0;
      if (vld_p0) begin
         pc_p1    <= pc_w;
         first_p1 <= first_p0;
         last_p1  <= last_p0;
         cls_p1   <= cls_p0;
      end
   end

   assign acc_next = (first_p1 ? '0 : acc_q) + SCORE_W'(pc_p1);

   // ---- stage p2: accumulate per class, strict-greater argmax at class end ----
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q        <= '0;
         best_score_q <= '0;
         best_class_q <= '0;
         bv_q         <= 1'b0;
      end else if (start_acc) begin
         best_score_q <= '0;
         best_class_q <= '0;
         bv_q         <= 1'b0;
      end else if (vld_p1) begin
         acc_q <= acc_next;
         if (last_p1 && (!bv_q || (acc_next > best_score_q))) begin
            best_score_q <= acc_next;
            best_class_q <= cls_p1;
            bv_q         <= 1'b1;
         end
      end
   end

   assign best_class = best_class_q;
   assign best_score = best_score_q;
endmodule

// File: tb/tb_assoc_search_seq_ctrl.sv
// Directed bench: a small instance (4 classes x 2 chunks) driven from a vector
// table plus hand sequences, and a default-size instance for the full-width score.
module tb_assoc_search_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // small instance
   logic         start_s = 1'b0;
   logic         q_en_s, c_en_s, busy_s, done_s;
   logic [1:0]   q_addr_s;
   logic [5:0]   c_addr_s;
   logic [511:0] q_rd_s = '0, c_rd_s = '0;
   logic [3:0]   best_class_s;
   logic [11:0]  best_score_s;
   logic [511:0] qm_s [0:3];
   logic [511:0] cm_s [0:63];

   // default-size instance
   logic         start_b = 1'b0;
   logic         q_en_b, c_en_b, busy_b, done_b;
   logic [1:0]   q_addr_b;
   logic [5:0]   c_addr_b;
   logic [511:0] q_rd_b = '0, c_rd_b = '0;
   logic [3:0]   best_class_b;
   logic [11:0]  best_score_b;
   logic [511:0] qm_b [0:3];
   logic [511:0] cm_b [0:63];

   assoc_search_seq_ctrl #(.NUM_CLASSES(4), .CHUNKS(2)) dut (
      .clk(clk), .rst(rst), .start(start_s),
      .q_en(q_en_s), .q_addr(q_addr_s), .q_rdata(q_rd_s),
      .c_en(c_en_s), .c_addr(c_addr_s), .c_rdata(c_rd_s),
      .busy(busy_s), .done(done_s),
      .best_class(best_class_s), .best_score(best_score_s)
   );

   assoc_search_seq_ctrl dut_big (
      .clk(clk), .rst(rst), .start(start_b),
      .q_en(q_en_b), .q_addr(q_addr_b), .q_rdata(q_rd_b),
      .c_en(c_en_b), .c_addr(c_addr_b), .c_rdata(c_rd_b),
      .busy(busy_b), .done(done_b),
      .best_class(best_class_b), .best_score(best_score_b)
   );

   // synchronous memories, one cycle read latency
   always @(posedge clk) begin
      if (q_en_s) q_rd_s <= qm_s[q_addr_s];
      if (c_en_s) c_rd_s <= cm_s[c_addr_s];
      if (q_en_b) q_rd_b <= qm_b[q_addr_b];
      if (c_en_b) c_rd_b <= cm_b[c_addr_b];
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   function automatic logic [511:0] ones(input int n, input int off);
      logic [511:0] v;
      for (int i = 0; i < 512; i++) v[i] = (i >= off) && (i < off + n);
      return v;
   endfunction

   typedef struct {
      int qones;      // query ones per chunk, from bit 0
      int coff;       // first set bit of each class chunk
      int cones [4];  // class ones per chunk
      int exp_cls;
      int exp_score;
   } vec_t;

   vec_t tab [5];
   int   alog [0:63];
   int   qlog [0:63];
   int   nlog;

   task automatic load_small(input vec_t v);
      for (int k = 0; k < 4; k++) qm_s[k] = ones(v.qones, 0);
      for (int c = 0; c < 4; c++)
         for (int k = 0; k < 2; k++) cm_s[c*2+k] = ones(v.cones[c], v.coff);
   endtask

   // Ends in cycle 1 of the search (just after the edge that accepted start).
   task automatic start_small();
      @(negedge clk) start_s = 1'b1;
      @(posedge clk);
      #1 start_s = 1'b0;
   endtask

   // Returns the cycle number at which done is seen (200 on timeout); logs
   // issued addresses; optionally pulses start during cycle pulse_at.
   task automatic wait_done_small(input int pulse_at, output int cyc);
      cyc  = 1;
      nlog = 0;
      forever begin
         if (c_en_s && nlog < 64) begin
            alog[nlog] = int'(c_addr_s);
            qlog[nlog] = int'(q_addr_s);
            nlog++;
         end
         if (done_s || cyc >= 200) break;
         start_s = (cyc + 1 == pulse_at);
         @(posedge clk);
         #1;
         cyc++;
      end
      start_s = 1'b0;
   endtask

   initial begin
      int cyc;
      int seen;
      logic [511:0] r;

      tab[0] = '{512,   0, '{ 64, 128, 192, 256}, 3, 512};
      tab[1] = '{  0,   0, '{200, 200, 200, 200}, 0,   0};
      tab[2] = '{512,   0, '{100, 150, 150,  50}, 1, 300};
      tab[3] = '{256, 128, '{ 64, 200,  40,  10}, 1, 256};
      tab[4] = '{512,   0, '{500,  10, 499, 500}, 0, 1000};

      for (int i = 0; i < 4; i++) begin qm_s[i] = '0; qm_b[i] = '0; end
      for (int i = 0; i < 64; i++) begin cm_s[i] = '0; cm_b[i] = '0; end

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      chk("rst_busy",  int'(busy_s), 0);
      chk("rst_done",  int'(done_s), 0);
      chk("rst_en",    int'(q_en_s) + int'(c_en_s), 0);
      chk("rst_class", int'(best_class_s), 0);
      chk("rst_score", int'(best_score_s), 0);

      // table-driven searches
      for (int t = 0; t < 5; t++) begin
         load_small(tab[t]);
         start_small();
         chk($sformatf("v%0d_busy_c1", t), int'(busy_s), 1);
         wait_done_small(0, cyc);
         chk($sformatf("v%0d_done_cycle", t), cyc, 11);
         chk($sformatf("v%0d_class", t), int'(best_class_s), tab[t].exp_cls);
         chk($sformatf("v%0d_score", t), int'(best_score_s), tab[t].exp_score);
         chk($sformatf("v%0d_busy_done", t), int'(busy_s), 0);
         @(posedge clk); #1;
         chk($sformatf("v%0d_done_pulse", t), int'(done_s), 0);
         repeat (3) @(posedge clk); #1;
         chk($sformatf("v%0d_hold", t), int'(best_score_s), tab[t].exp_score);
      end

      // start pulsed mid-search is ignored
      load_small(tab[0]);
      start_small();
      wait_done_small(5, cyc);
      chk("busy_start_done_cycle", cyc, 11);
      chk("busy_start_nissue", nlog, 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("seq_c_addr%0d", i), alog[i], i);
         chk($sformatf("seq_q_addr%0d", i), qlog[i], i % 2);
      end
      chk("busy_start_score", int'(best_score_s), 512);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         seen += int'(done_s) + int'(busy_s);
      end
      chk("busy_start_no_restart", seen, 0);

      // reset in cycle 4, then a fresh search
      load_small(tab[2]);
      start_small();
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid_rst_busy", int'(busy_s), 0);
      chk("mid_rst_en", int'(c_en_s), 0);
      chk("mid_rst_score", int'(best_score_s), 0);
      chk("mid_rst_class", int'(best_class_s), 0);
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         seen += int'(done_s);
      end
      chk("mid_rst_no_done", seen, 0);
      start_small();
      wait_done_small(0, cyc);
      chk("rerun_done_cycle", cyc, 11);
      chk("rerun_class", int'(best_class_s), 1);
      chk("rerun_score", int'(best_score_s), 300);

      // default size: class 7 equals the all-ones query
      for (int k = 0; k < 4; k++) qm_b[k] = ones(512, 0);
      for (int c = 0; c < 16; c++)
         for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 16; w++)
               r[w*32 +: 32] = $urandom & $urandom & $urandom;
            cm_b[c*4+k] = (c == 7) ? ones(512, 0) : r;
         end
      @(negedge clk) start_b = 1'b1;
      @(posedge clk);
      #1 start_b = 1'b0;
      cyc = 1;
      while (!done_b && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("big_done_cycle", cyc, 67);
      chk("big_class", int'(best_class_b), 7);
      chk("big_score", int'(best_score_b), 2048);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
